skew_operand_buffer: RTL

SKEW_OPERAND_BUFFER -- requirements
Module: skew_operand_buffer

---
 rtl/skew_buf_pkg.sv | 17 +
 rtl/skew_idx_counter.sv | 45 ++++
 rtl/skew_operand_buffer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/skew_buf_pkg.sv
// Shared types and constants for the skewed operand buffer.
package skew_buf_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam logic ORDER_WS = 1'b0;
  localparam logic ORDER_OS = 1'b1;

  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/skew_idx_counter.sv
// Two-level wrap counter: inner runs 0..i_inner_max, then outer steps and wraps at i_outer_max.
module skew_idx_counter #(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic [IDX_W-1:0] i_inner_max,
  input  logic [IDX_W-1:0] i_outer_max,
  output logic [IDX_W-1:0] o_inner,
  output logic [IDX_W-1:0] o_outer,
  output logic             o_wrap
);

  logic [IDX_W-1:0] r_inner;
  logic [IDX_W-1:0] r_outer;
  logic             w_inner_end;
  logic             w_outer_end;

  assign w_inner_end = (r_inner == i_inner_max);
  assign w_outer_end = (r_outer == i_outer_max);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inner <= '0;
      r_outer <= '0;
    end else if (i_clear) begin
      r_inner <= '0;
      r_outer <= '0;
    end else if (i_advance) begin
      if (w_inner_end) begin
        r_inner <= '0;
        r_outer <= w_outer_end ? '0 : r_outer + IDX_W'(1);
      end else begin
        r_inner <= r_inner + IDX_W'(1);
      end
    end
  end

  assign o_inner = r_inner;
  assign o_outer = r_outer;
  assign o_wrap  = w_inner_end & w_outer_end;

endmodule

// File: rtl/skew_operand_buffer.sv
// Loads an N x K operand tile in either order and drains it diagonally skewed, one lane per row,
// so element (r,c) appears on beat r+c.
module skew_operand_buffer
  import skew_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned MAX_K      = 8,
  parameter int unsigned IDX_W      = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [IDX_W-1:0]           cfg_n,
  input  logic [IDX_W-1:0]           cfg_k,
  input  logic                       cfg_order,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ROWS*DATA_WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       err_cfg
);

  localparam int unsigned DEPTH  = MAX_K + ROWS - 1;
  localparam int unsigned SLOT_W = clog2_min1(DEPTH);
  localparam int unsigned ROW_W  = clog2_min1(ROWS);

  state_e                  r_state;
  logic [IDX_W-1:0]        r_n;
  logic [IDX_W-1:0]        r_k;
  logic                    r_order;
  logic                    r_err;
  logic [SLOT_W-1:0]       r_beat;
  logic [SLOT_W-1:0]       r_last_beat;
  logic [DATA_WIDTH-1:0]   r_mem [ROWS][DEPTH];
  logic [DEPTH-1:0]        r_vld [ROWS];

  logic                    w_cfg_ok;
  logic                    w_start_ok;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_is_last;
  logic [IDX_W-1:0]        w_inner_max;
  logic [IDX_W-1:0]        w_outer_max;
  logic [IDX_W-1:0]        w_inner;
  logic [IDX_W-1:0]        w_outer;
  logic                    w_cnt_wrap;
  logic [IDX_W-1:0]        w_row;
  logic [IDX_W-1:0]        w_col;
  logic [ROW_W-1:0]        w_row_idx;
  logic [SLOT_W-1:0]       w_slot;

  assign w_cfg_ok = (cfg_n != '0) && (cfg_n <= IDX_W'(ROWS)) &&
                    (cfg_k != '0) && (cfg_k <= IDX_W'(MAX_K));
  assign w_start_ok = (r_state == StIdle) && start && w_cfg_ok;
  assign w_in_fire  = (r_state == StLoad) && in_valid;
  assign w_out_fire = (r_state == StDrain) && out_ready;
  assign w_is_last  = (r_beat == r_last_beat);

  // Lane-major walks columns fastest; element-major walks rows fastest.
  assign w_inner_max = (r_order == ORDER_OS) ? r_n - IDX_W'(1) : r_k - IDX_W'(1);
  assign w_outer_max = (r_order == ORDER_OS) ? r_k - IDX_W'(1) : r_n - IDX_W'(1);
  assign w_row       = (r_order == ORDER_OS) ? w_inner : w_outer;
  assign w_col       = (r_order == ORDER_OS) ? w_outer : w_inner;
  assign w_row_idx   = ROW_W'(w_row);
  assign w_slot      = SLOT_W'(w_row) + SLOT_W'(w_col);

  skew_idx_counter #(
    .IDX_W(IDX_W)
  ) u_idx_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_start_ok),
    .i_advance  (w_in_fire),
    .i_inner_max(w_inner_max),
    .i_outer_max(w_outer_max),
    .o_inner    (w_inner),
    .o_outer    (w_outer),
    .o_wrap     (w_cnt_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_n         <= '0;
      r_k         <= '0;
      r_order     <= ORDER_WS;
      r_err       <= 1'b0;
      r_beat      <= '0;
      r_last_beat <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_n         <= cfg_n;
              r_k         <= cfg_k;
              r_order     <= cfg_order;
              r_err       <= 1'b0;
              r_beat      <= '0;
              // Wraps modulo 2^SLOT_W but the true value N+K-2 always fits.
              r_last_beat <= SLOT_W'(cfg_n) + SLOT_W'(cfg_k) - SLOT_W'(2);
              r_state     <= StLoad;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (w_in_fire && w_cnt_wrap) begin
            r_beat  <= '0;
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_out_fire) begin
            if (w_is_last) begin
              r_beat  <= '0;
              r_state <= StIdle;
            end else begin
              r_beat <= r_beat + SLOT_W'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        r_vld[r] <= '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
          r_mem[r][s] <= '0;
        end
      end
    end else if (w_start_ok) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        r_vld[r] <= '0;
      end
    end else if (w_in_fire) begin
      r_mem[w_row_idx][w_slot] <= in_data;
      r_vld[w_row_idx][w_slot] <= 1'b1;
    end
  end

  always_comb begin
    in_ready  = (r_state == StLoad);
    busy      = (r_state != StIdle);
    out_valid = (r_state == StDrain);
    out_last  = (r_state == StDrain) && w_is_last;
    err_cfg   = r_err;
    out_data  = '0;
    // Lanes beyond N never get a valid bit, so they drain as zero.
    if (r_state == StDrain) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (r_vld[r][r_beat]) begin
          out_data[r*DATA_WIDTH +: DATA_WIDTH] = r_mem[r][r_beat];
        end
      end
    end
  end

endmodule
